// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   PARITY_*            : parity mode encodings for the PARITY_MODE parameter
//   rx_state_t          : deframer FSM states
//   calc_clks_per_bit   : derives the oversampling ratio from clock and baud rate
//   clks_per_bit_legal  : true when the ratio leaves room for a mid-bit sample
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud_bps);
    return clk_hz / baud_bps;
  endfunction

  function automatic bit clks_per_bit_legal(input int clks_per_bit);
    return clks_per_bit >= 4;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
//   clk, reset : system clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data; accepted at full only with a same-cycle pop
//   pop        : removes the head entry; ignored when empty
//   rdata      : head entry (combinational from the read pointer)
//   count      : number of stored entries; full / empty status flags
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with a buffered valid/ready output stream.
//   clk, reset     : system clock, synchronous active-high reset
//   uart_rxd       : asynchronous serial input
//   uart_rts_n     : 0 = peer may send, 1 = stop (FIFO nearly full)
//   rx_data        : head-of-FIFO character
//   rx_frame_err   : head word had a stop bit sampled 0
//   rx_parity_err  : head word failed the parity check
//   rx_valid       : FIFO non-empty
//   rx_ready       : consumer pops the head when rx_valid && rx_ready
//   rx_break       : one-cycle pulse on a break character
//   overrun        : sticky, a character was dropped on a full FIFO
//   clr_overrun    : clears overrun (a simultaneous new overrun wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 12_000_000,
  parameter int BAUD_RATE_BPS = 3_000_000,
  parameter int CLKS_PER_BIT  = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE_BPS),
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = PARITY_NONE,
  parameter int STOP_BITS     = 1,
  parameter int RX_INVERT     = 0,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_MARGIN    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic                 uart_rts_n,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_break,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  if (!clks_per_bit_legal(CLKS_PER_BIT)) begin : g_bad_cpb
    $error("uart_rx_fifo: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 4");
  end
  if (RTS_MARGIN >= FIFO_DEPTH) begin : g_bad_margin
    $error("uart_rx_fifo: RTS_MARGIN must be below FIFO_DEPTH");
  end

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int               FW        = DATA_BITS + 2;
  localparam int               CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    RTS_LEVEL = CW'(FIFO_DEPTH - RTS_MARGIN);
  localparam logic             INV       = (RX_INVERT != 0);
  localparam logic             ODD_SENSE = (PARITY_MODE == PARITY_ODD);

  logic                 sync1;
  logic                 sync2;
  logic                 rxl;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frame_err;
  logic                 stop_one;
  logic                 done;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic [FW-1:0]        rdata;

  // Synchroniser resets to the idle line level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= ~INV;
      sync2 <= ~INV;
    end else begin
      sync1 <= uart_rxd;
      sync2 <= sync1;
    end
  end

  assign rxl = sync2 ^ INV;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      stop_one  <= 1'b0;
      done      <= 1'b0;
      rx_break  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_break <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxl) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_BIT) begin
            cnt <= '0;
            if (rxl) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              bit_idx   <= '0;
              par_err   <= 1'b0;
              frame_err <= 1'b0;
              stop_one  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_TICK) begin
            cnt   <= '0;
            shreg <= {rxl, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST_TICK) begin
            cnt     <= '0;
            par_err <= ((^shreg) ^ rxl) != ODD_SENSE;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_TICK) begin
            cnt <= '0;
            if (!rxl) frame_err <= 1'b1;
            if (rxl)  stop_one  <= 1'b1;
            if (bit_idx == LAST_STOP) begin
              bit_idx  <= '0;
              state    <= IDLE;
              // Word fields settle here; the FIFO write happens on the next edge.
              done     <= 1'b1;
              rx_break <= (shreg == '0) && !stop_one && !rxl;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = rx_valid && rx_ready;

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (done),
    .pop   (pop),
    .wdata ({par_err, frame_err, shreg}),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid      = !empty;
  assign rx_data       = rdata[DATA_BITS-1:0];
  assign rx_frame_err  = rdata[DATA_BITS];
  assign rx_parity_err = rdata[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      uart_rts_n <= 1'b1;
    end else begin
      if (done && full && !pop) overrun <= 1'b1;
      else if (clr_overrun)     overrun <= 1'b0;
      uart_rts_n <= (count >= RTS_LEVEL);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: an 8N1 instance (a) and an 8E1
// instance (b), driven with directed frames and random traffic, compared
// against a queue-based model of the receiver's externally visible behaviour.
module tb_uart_rx_fifo;

  localparam int CPB       = 12_000_000 / 3_000_000;
  localparam int FRAME_A   = CPB * 10;
  // rxd start edge to rx_valid: 2 sync flops + detect + half-bit wait
  // + one bit per data/stop bit + write edge.
  localparam int LATENCY_A = 2 + 1 + (CPB / 2 + 1) + CPB * 9 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       rxd_a = 1'b1, rts_a, fe_a, pe_a, valid_a, ready_a = 1'b0, brk_a, ovr_a, clr_a = 1'b0;
  logic [7:0] data_a;
  logic       rxd_b = 1'b1, rts_b, fe_b, pe_b, valid_b, ready_b = 1'b0, brk_b, ovr_b;
  logic [7:0] data_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int va_rise = -1, va_cycles = 0, brk_cnt = 0, brk_cyc = -1, rts_rise = -1;
  logic prev_va = 1'b0, prev_rts = 1'b1;

  uart_rx_fifo u_dut_a (
    .clk (clk), .reset (reset), .uart_rxd (rxd_a), .uart_rts_n (rts_a),
    .rx_data (data_a), .rx_frame_err (fe_a), .rx_parity_err (pe_a),
    .rx_valid (valid_a), .rx_ready (ready_a), .rx_break (brk_a),
    .overrun (ovr_a), .clr_overrun (clr_a)
  );

  uart_rx_fifo #(.PARITY_MODE (1)) u_dut_b (
    .clk (clk), .reset (reset), .uart_rxd (rxd_b), .uart_rts_n (rts_b),
    .rx_data (data_b), .rx_frame_err (fe_b), .rx_parity_err (pe_b),
    .rx_valid (valid_b), .rx_ready (ready_b), .rx_break (brk_b),
    .overrun (ovr_b), .clr_overrun (1'b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer / observer: records popped words and timing of key events.
  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({pe_a, fe_a, data_a});
    if (valid_b && ready_b) got_b.push_back({pe_b, fe_b, data_b});
    if (valid_a) va_cycles <= va_cycles + 1;
    if (valid_a && !prev_va) va_rise <= cyc;
    prev_va <= valid_a;
    if (brk_a) begin
      brk_cnt <= brk_cnt + 1;
      brk_cyc <= cyc;
    end
    if (rts_a && !prev_rts) rts_rise <= cyc;
    prev_rts <= rts_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) rxd_a = b;
    else            rxd_b = b;
    tick(CPB);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                            input logic p, input logic stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, p);
    drive_bit(which, stop);
    if (which == 0) rxd_a = 1'b1;
    else            rxd_b = 1'b1;
  endtask

  // Reference model of one received word: {parity_err, frame_err, data}.
  function automatic logic [9:0] model_word(input logic [7:0] d, input int mode,
                                            input logic p, input logic stop);
    int   ones;
    logic pe;
    ones = $countones(d) + int'(p);
    if (mode == 1)      pe = (ones % 2) != 0;
    else if (mode == 2) pe = (ones % 2) != 1;
    else                pe = 1'b0;
    return {pe, ~stop, d};
  endfunction

  task automatic compare_a(input string tag);
    check({tag, "_count"}, got_a.size(), exp_a.size());
    while (exp_a.size() > 0) begin
      logic [9:0] e, g;
      e = exp_a.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 10'bx;
      check(tag, g, e);
    end
    got_a.delete();
  endtask

  task automatic compare_b(input string tag);
    check({tag, "_count"}, got_b.size(), exp_b.size());
    while (exp_b.size() > 0) begin
      logic [9:0] e, g;
      e = exp_b.pop_front();
      g = (got_b.size() > 0) ? got_b.pop_front() : 10'bx;
      check(tag, g, e);
    end
    got_b.delete();
  endtask

  initial begin
    int s, vc0, bc0, sz, rts_exp, exp_brk;
    logic [7:0] d;
    logic stop, p;

    // Reset state
    tick(3);
    check("reset_rts", rts_a, 1'b1);
    check("reset_valid", valid_a, 1'b0);
    check("reset_break", brk_a, 1'b0);
    check("reset_overrun", ovr_a, 1'b0);
    reset = 1'b0;
    check("rts_after_release", rts_a, 1'b1);
    tick(1);
    check("rts_second_cycle", rts_a, 1'b0);
    tick(4);

    // 8N1 0xA5 with immediate pop
    ready_a = 1'b1;
    ready_b = 1'b1;
    vc0 = va_cycles;
    s = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    exp_a.push_back(model_word(8'hA5, 0, 1'b0, 1'b1));
    tick(10);
    check("valid_latency", va_rise - s, LATENCY_A);
    check("valid_width", va_cycles - vc0, 1);
    check("valid_after_pop", valid_a, 1'b0);
    compare_a("a5_word");

    // 8E1 parity: 0x03 with parity bit 1 (mismatch) then 0 (match)
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    exp_b.push_back(model_word(8'h03, 1, 1'b1, 1'b1));
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    exp_b.push_back(model_word(8'h03, 1, 1'b0, 1'b1));
    tick(10);
    compare_b("parity_word");

    // Stop-bit faults: framing error without break, then a break
    bc0 = brk_cnt;
    send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
    exp_a.push_back(model_word(8'h7E, 0, 1'b0, 1'b0));
    tick(10);
    check("no_break_7e", brk_cnt - bc0, 0);
    compare_a("frame_err_7e");
    bc0 = brk_cnt;
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    exp_a.push_back(model_word(8'h00, 0, 1'b0, 1'b0));
    tick(10);
    check("break_pulse_count", brk_cnt - bc0, 1);
    check("break_aligned_write", brk_cyc, va_rise - 1);
    compare_a("break_word");

    // Glitch shorter than half a bit
    vc0 = va_cycles;
    rxd_a = 1'b0;
    tick(1);
    rxd_a = 1'b1;
    tick(30);
    check("glitch_no_valid", va_cycles - vc0, 0);
    check("glitch_valid_low", valid_a, 1'b0);
    compare_a("glitch_no_word");

    // Overflow with the consumer stalled
    ready_a = 1'b0;
    sz = 0;
    rts_exp = -1;
    s = cyc;
    for (int k = 0; k <= 16; k++) begin
      send_frame(0, 8'(k), 1'b0, 1'b0, 1'b1);
      if (sz < 16) begin
        exp_a.push_back(model_word(8'(k), 0, 1'b0, 1'b1));
        sz++;
        if (sz == 16 - 4) rts_exp = s + FRAME_A * k + LATENCY_A + 1;
      end
    end
    tick(10);
    check("rts_rise_cycle", rts_rise, rts_exp);
    check("overrun_set", ovr_a, 1'b1);
    check("full_valid", valid_a, 1'b1);
    ready_a = 1'b1;
    tick(25);
    compare_a("drain");
    check("overrun_sticky", ovr_a, 1'b1);
    check("rts_after_drain", rts_a, 1'b0);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("overrun_cleared", ovr_a, 1'b0);

    // Reset in the middle of a frame with a word already buffered
    ready_a = 1'b0;
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    tick(5);
    check("pre_reset_valid", valid_a, 1'b1);
    d = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
    reset = 1'b1;
    rxd_a = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_valid", valid_a, 1'b0);
    check("midreset_rts", rts_a, 1'b1);
    check("midreset_overrun", ovr_a, 1'b0);
    check("midreset_break", brk_a, 1'b0);
    tick(1);
    check("midreset_rts_low", rts_a, 1'b0);
    got_a.delete();
    ready_a = 1'b1;
    tick(3);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    exp_a.push_back(model_word(8'h5A, 0, 1'b0, 1'b1));
    tick(10);
    compare_a("post_reset_5a");

    // Random traffic on both instances
    bc0 = brk_cnt;
    exp_brk = 0;
    for (int k = 0; k < 24; k++) begin
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 1'b0, 1'b0, stop);
      exp_a.push_back(model_word(d, 0, 1'b0, stop));
      if (d == 8'h00 && !stop) exp_brk++;
      tick(CPB * $urandom_range(0, 2));
    end
    tick(60);
    check("random_breaks", brk_cnt - bc0, exp_brk);
    compare_a("random_a");

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(1, d, 1'b1, p, stop);
      exp_b.push_back(model_word(d, 1, p, stop));
      tick(CPB * $urandom_range(0, 2));
    end
    tick(60);
    compare_b("random_b");
    check("b_overrun", ovr_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
